// File: rtl/xgmii_rx_decoder.sv
// xgmii_rx_decoder
//   Decodes a 64-bit XGMII receive stream (8 lanes) into AXI-Stream style
//   frame beats. Frames start with a Start character in lane 0 or lane 4
//   followed by preamble/SFD; payload begins at lane 0 of the next word.
//   Each data word is parked in a one-word hold register and released when
//   the following word is decoded, so tlast can be attached to the right beat.
//
// Ports
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_xgmii_rxd/rxc      : XGMII data (lane n = bits [8n+7:8n]) and control flags
//   o_axis_tdata/tkeep   : beat data and contiguous byte-valid mask
//   o_axis_tvalid/tlast  : beat valid (no back-pressure) and end of frame
//   o_axis_tuser         : frame error, meaningful only with tlast
//   o_frame_cnt          : frames completed without error (wraps)
//   o_err_cnt            : errored or dropped frames (wraps)
module xgmii_rx_decoder #(
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_xgmii_rxd,
    input  logic [7:0]  i_xgmii_rxc,
    output logic [63:0] o_axis_tdata,
    output logic [7:0]  o_axis_tkeep,
    output logic        o_axis_tvalid,
    output logic        o_axis_tlast,
    output logic        o_axis_tuser,
    output logic [31:0] o_frame_cnt,
    output logic [31:0] o_err_cnt
);

    localparam logic [7:0]  CH_START  = 8'hFB;
    localparam logic [7:0]  CH_TERM   = 8'hFD;
    localparam logic [7:0]  CH_IDLE   = 8'h07;
    localparam logic [63:0] HDR_LANE0 = 64'hD555_5555_5555_55FB;
    localparam logic [31:0] HDR_LANE4 = 32'hD555_55FB;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DROP} state_t;

    state_t      state_q, state_d;
    logic [63:0] rxd_q, rxd_d;
    logic [7:0]  rxc_q, rxc_d;
    logic [63:0] hold_data_q, hold_data_d;
    logic [7:0]  hold_keep_q, hold_keep_d;
    logic        hold_vld_q, hold_vld_d;
    logic [13:0] byte_cnt_q, byte_cnt_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Lane decode of the registered input word
    logic [7:0]  term_mask, below_mask;
    logic [3:0]  term_lane, n_bytes;
    logic        term_any, ctrl_err, oversize, start0, start4, idle0;
    logic [14:0] byte_sum;

    always_comb begin
        term_mask  = '0;
        below_mask = '0;
        term_lane  = 4'd8;
        for (int i = 0; i < 8; i++)
            term_mask[i] = rxc_q[i] && (rxd_q[8*i +: 8] == CH_TERM);
        for (int i = 7; i >= 0; i--)
            if (term_mask[i]) term_lane = 4'(i);
        // Lanes below the first Terminate (all lanes if none); only these are checked
        for (int i = 0; i < 8; i++)
            below_mask[i] = (4'(i) < term_lane);
    end

    assign term_any = |term_mask;
    // Any control below the Terminate lane is an error (Error, Start, Idle, ...)
    assign ctrl_err = |(rxc_q & below_mask);
    assign n_bytes  = term_any ? term_lane : 4'd8;
    assign byte_sum = {1'b0, byte_cnt_q} + 15'(n_bytes);
    assign oversize = byte_sum > 15'(MAX_FRAME_BYTES);
    assign start0   = rxc_q[0] && (rxd_q[7:0] == CH_START);
    assign start4   = rxc_q[4] && (rxd_q[39:32] == CH_START);
    assign idle0    = rxc_q[0] && (rxd_q[7:0] == CH_IDLE);

    logic emit, emit_last, emit_err, err_inc;

    always_comb begin
        state_d     = state_q;
        rxd_d       = i_xgmii_rxd;
        rxc_d       = i_xgmii_rxc;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hold_vld_d  = hold_vld_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        emit        = 1'b0;
        emit_last   = 1'b0;
        emit_err    = 1'b0;
        err_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A held word here is always the partial tail of a terminated frame
                emit       = hold_vld_q;
                emit_last  = 1'b1;
                hold_vld_d = 1'b0;
                if (start0 || start4) begin
                    byte_cnt_d = '0;
                    if (start0 ? (rxc_q == 8'h01 && rxd_q == HDR_LANE0)
                               : (rxc_q[7:4] == 4'b0001 && rxd_q[63:32] == HDR_LANE4)) begin
                        state_d = ST_DATA;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                emit = hold_vld_q;
                if (ctrl_err) begin
                    emit_last  = 1'b1;
                    emit_err   = 1'b1;
                    err_inc    = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = term_any ? ST_IDLE : ST_DROP;
                end else if (oversize) begin
                    emit_last  = 1'b1;
                    emit_err   = 1'b1;
                    err_inc    = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = ST_DROP;
                end else if (term_any && term_lane == 4'd0) begin
                    emit_last  = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    // Full word, or partial word that IDLE releases with tlast next cycle
                    hold_data_d = rxd_q;
                    hold_keep_d = term_any ? below_mask : 8'hFF;
                    hold_vld_d  = 1'b1;
                    byte_cnt_d  = byte_sum[13:0];
                    if (term_any) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (term_any || idle0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        tvalid_d = emit;
        tlast_d  = emit && emit_last;
        tuser_d  = emit && emit_err;
        tdata_d  = emit ? hold_data_q : '0;
        tkeep_d  = emit ? hold_keep_q : '0;
        if (emit && emit_last && !emit_err) frame_cnt_d = frame_cnt_q + 32'd1;
        if (err_inc) err_cnt_d = err_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            rxd_q       <= '0;
            rxc_q       <= '0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_vld_q  <= 1'b0;
            byte_cnt_q  <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            rxc_q       <= rxc_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_vld_q  <= hold_vld_d;
            byte_cnt_q  <= byte_cnt_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_axis_tdata  = tdata_q;
    assign o_axis_tkeep  = tkeep_q;
    assign o_axis_tvalid = tvalid_q;
    assign o_axis_tlast  = tlast_q;
    assign o_axis_tuser  = tuser_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Testbench for xgmii_rx_decoder: directed frames, expected beats queued
// from a frame-level model and compared as the DUT emits them.
module tb_xgmii_rx_decoder;

    localparam int MAXB = 64;
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic [63:0] o_axis_tdata;
    logic [7:0]  o_axis_tkeep;
    logic        o_axis_tvalid, o_axis_tlast, o_axis_tuser;
    logic [31:0] o_frame_cnt, o_err_cnt;

    xgmii_rx_decoder #(.MAX_FRAME_BYTES(MAXB)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_xgmii_rxd(rxd), .i_xgmii_rxc(rxc),
        .o_axis_tdata(o_axis_tdata), .o_axis_tkeep(o_axis_tkeep),
        .o_axis_tvalid(o_axis_tvalid), .o_axis_tlast(o_axis_tlast),
        .o_axis_tuser(o_axis_tuser),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        int          cyc;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_fails  = 0;
    int exp_frames = 0;
    int exp_errs   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one word; it is sampled at the next rising edge
    task automatic send(input logic [63:0] d, input logic [7:0] c);
        rxd = d;
        rxc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic u, input int at);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.user = u; b.cyc = at;
        sb.push_back(b);
    endtask

    // Build and send one frame; expected beats are derived word by word.
    // Beat for data word j (sampled at edge base+j) must appear at edge base+j+2.
    task automatic run_frame(input bit lane4, input bit hdr_ok, input int nfull,
                             input int k, input int err_idx, input int gap);
        logic [63:0] w[$];
        logic [7:0]  c[$];
        logic [63:0] sd, td;
        logic [7:0]  sc, tc;
        int base, cnt, held, nb;
        base = cyc + 1;
        if (lane4) begin sd = {8'hD5, 8'h55, 8'h55, 8'hFB, 32'h0707_0707}; sc = 8'h1F; end
        else       begin sd = 64'hD555_5555_5555_55FB; sc = 8'h01; end
        if (!hdr_ok) begin
            if (lane4) sd[47:40] = 8'h54; else sd[63:56] = 8'h55;
        end
        for (int j = 1; j <= nfull; j++) begin
            td = {$urandom, $urandom};
            tc = 8'h00;
            if (j == err_idx) begin td[23:16] = 8'hFE; tc = 8'h04; end
            w.push_back(td); c.push_back(tc);
        end
        td = {$urandom, $urandom};
        tc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == k)     begin td[8*i +: 8] = 8'hFD; tc[i] = 1'b1; end
            else if (i > k) begin td[8*i +: 8] = 8'h07; tc[i] = 1'b1; end
        end
        w.push_back(td); c.push_back(tc);

        if (!hdr_ok) exp_errs++;
        else begin
            cnt = 0; held = 0;
            for (int j = 1; j <= nfull + 1; j++) begin
                nb = (j == nfull + 1) ? k : 8;
                if (j == err_idx || cnt + nb > MAXB) begin
                    if (held != 0) push(w[held-1], 8'hFF, 1'b1, 1'b1, base + held + 2);
                    exp_errs++;
                    break;
                end
                if (j == nfull + 1) begin
                    if (k == 0) begin
                        if (held != 0) push(w[held-1], 8'hFF, 1'b1, 1'b0, base + held + 2);
                    end else begin
                        if (held != 0) push(w[held-1], 8'hFF, 1'b0, 1'b0, base + held + 2);
                        push(w[j-1], 8'((9'd1 << k) - 9'd1), 1'b1, 1'b0, base + j + 2);
                    end
                    exp_frames++;
                    break;
                end
                if (held != 0) push(w[held-1], 8'hFF, 1'b0, 1'b0, base + held + 2);
                held = j;
                cnt += nb;
            end
        end

        send(sd, sc);
        for (int j = 0; j < w.size(); j++) send(w[j], c[j]);
        for (int g = 0; g < gap; g++) send(IDLE_W, 8'hFF);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_frames));
        check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(exp_errs));
        check({tag, "_beats_pending"}, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: every beat must match the head of the scoreboard
    beat_t  mb;
    logic [63:0] mask;
    always @(negedge clk) begin
        if (o_axis_tvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'(o_axis_tvalid), 64'd0);
            end else begin
                mb = sb.pop_front();
                for (int i = 0; i < 8; i++) mask[8*i +: 8] = {8{mb.keep[i]}};
                check("beat_data", o_axis_tdata & mask, mb.data & mask);
                check("beat_keep", 64'(o_axis_tkeep), 64'(mb.keep));
                check("beat_last", 64'(o_axis_tlast), 64'(mb.last));
                check("beat_user", 64'(o_axis_tuser), 64'(mb.user));
                check("beat_cycle", 64'(cyc), 64'(mb.cyc));
            end
        end else begin
            check("idle_last_user", {62'd0, o_axis_tlast, o_axis_tuser}, 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        rxd = IDLE_W;
        rxc = 8'hFF;
        repeat (3) send(IDLE_W, 8'hFF);
        check("rst_tvalid", 64'(o_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(o_axis_tlast), 64'd0);
        check("rst_tuser", 64'(o_axis_tuser), 64'd0);
        check("rst_tdata", o_axis_tdata, 64'd0);
        check("rst_tkeep", 64'(o_axis_tkeep), 64'd0);
        check("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
        check("rst_err_cnt", 64'(o_err_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) send(IDLE_W, 8'hFF);

        run_frame(0, 1, 8, 0, 0, 3);  check_counts("lane0_8w_exact_max");
        run_frame(1, 1, 7, 3, 0, 3);  check_counts("lane4_term3");
        run_frame(0, 1, 6, 5, 4, 3);  check_counts("error_char_word4");
        run_frame(0, 1, 2, 7, 0, 3);  check_counts("after_error");
        run_frame(0, 1, 10, 0, 0, 3); check_counts("oversize_10w");
        run_frame(0, 1, 8, 1, 0, 3);  check_counts("oversize_on_term");
        run_frame(0, 0, 2, 0, 0, 3);  check_counts("bad_sfd");
        run_frame(1, 0, 2, 2, 0, 3);  check_counts("bad_preamble_lane4");
        run_frame(0, 1, 0, 4, 0, 0);
        run_frame(1, 1, 3, 6, 0, 3);  check_counts("back_to_back");

        // Reset in the middle of a frame: nothing emitted, counters cleared
        send(64'hD555_5555_5555_55FB, 8'h01);
        send({$urandom, $urandom}, 8'h00);
        rst_n = 1'b0;
        send(IDLE_W, 8'hFF);
        check("midrst_tvalid", 64'(o_axis_tvalid), 64'd0);
        check("midrst_tlast", 64'(o_axis_tlast), 64'd0);
        check("midrst_tdata", o_axis_tdata, 64'd0);
        check("midrst_frame_cnt", 64'(o_frame_cnt), 64'd0);
        check("midrst_err_cnt", 64'(o_err_cnt), 64'd0);
        exp_frames = 0;
        exp_errs   = 0;
        send(IDLE_W, 8'hFF);
        rst_n = 1'b1;
        send({$urandom, $urandom}, 8'h00);
        send(64'h0707_0707_0707_07FD, 8'hFF);
        repeat (3) send(IDLE_W, 8'hFF);
        check_counts("after_reset_no_start");
        run_frame(0, 1, 1, 0, 0, 3);  check_counts("after_reset_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
